instr_fetch_unit: RTL

- Front-end stage of the RISC-V core.
- Holds the program counter and issues one instruction-memory read at a time.
- Captures the returned word into an instruction register.
- Presents the decoded fields (Op, Funct3, Funct7, register indices) to the control unit and register file under a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing any in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// ----------------
// Front-end fetch stage of the RISC-V core. It holds the program counter,
// issues one instruction-memory read at a time, captures the returned word
// into an instruction register and presents it, with its decoded fields,
// under a valid/ready handshake. A redirect from execute loads a new PC and
// flushes whatever fetch is in flight.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   NOP_INSTR  instruction register reset value (addi x0,x0,0)
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   imem_req/imem_addr         read request and word-aligned fetch address
//   imem_ready                 memory accepts the request this cycle
//   imem_rvalid/imem_rdata     returned instruction word
//   redirect_valid/redirect_pc branch/jump target from execute
//   out_valid/out_ready        handshake for the held instruction
//   out_pc/out_instr           PC and word of the held instruction
//   Op,Funct3,Funct7,Rd,Rs1,Rs2 decoded slices of out_instr
//   out_illegal                held word is not a 32-bit encoding
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [6:0]  Op,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7,
    output logic [4:0]  Rd,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic        out_illegal
);

    // S_REQ: ready to issue, S_WAIT: waiting for a wanted response,
    // S_DRAIN: waiting for a response that a redirect has made stale.
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_valid_q, out_valid_d;
    logic        slot_free;
    logic        capture;

    // Request generation. A request is only issued when the instruction
    // register will be free to take its response, so a capture never has
    // to overwrite a live instruction. Reset suppresses the request so the
    // memory never sees one during the reset cycle.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        imem_req  = !reset && (state_q == S_REQ) && slot_free && !redirect_valid;
        imem_addr = pc_q;
        capture   = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    end

    // Next-state logic. A redirect wins over everything else; when it hits
    // a fetch still in flight we have to drain that response, unless the
    // response arrives in the same cycle and can simply be dropped.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_valid_d = out_valid_q;

        if (redirect_valid) begin
            pc_d        = redirect_pc & ~32'h3;
            out_valid_d = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_req && imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        out_instr_d = imem_rdata;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                        state_d     = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_instr_q <= NOP_INSTR;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Decoded fields are plain slices of the held word, so they stay
    // stable for as long as the instruction register is held.
    always_comb begin
        out_valid   = out_valid_q;
        out_pc      = out_pc_q;
        out_instr   = out_instr_q;
        Op          = out_instr_q[6:0];
        Funct3      = out_instr_q[14:12];
        Funct7      = out_instr_q[31:25];
        Rd          = out_instr_q[11:7];
        Rs1         = out_instr_q[19:15];
        Rs2         = out_instr_q[24:20];
        out_illegal = out_valid_q && (out_instr_q[1:0] != 2'b11);
    end

endmodule
